// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes, ALU
// control codes, datapath mux encodings, FSM states and the control word.
package mips_ctrl_pkg;

  // Opcode field values
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALU control codes understood by the ALU control decoder
  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SLT     = 4'b0111;
  localparam logic [3:0] ALU_ADDU    = 4'b1000;
  localparam logic [3:0] ALU_XOR     = 4'b1010;
  localparam logic [3:0] ALU_SLTU    = 4'b1011;
  localparam logic [3:0] ALU_LUI     = 4'b1110;
  localparam logic [3:0] ALUOP_FUNCT = 4'b1111;

  // Datapath mux encodings
  localparam logic [1:0] M2R_ALUOUT   = 2'b00;
  localparam logic [1:0] M2R_MDR      = 2'b01;
  localparam logic [1:0] M2R_PC       = 2'b10;
  localparam logic [1:0] RDST_RT      = 2'b00;
  localparam logic [1:0] RDST_RD      = 2'b01;
  localparam logic [1:0] RDST_RA      = 2'b10;
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_R_WB     = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_LW_WB    = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_JAL      = 4'd11,
    S_EXEC_I   = 4'd12,
    S_I_WB     = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       sign_ext;
    logic [1:0] pc_source;
    logic [3:0] alu_op;
    logic       illegal;
  } ctrl_t;

  // State that follows DECODE for a given opcode; FETCH marks an unsupported one.
  function automatic state_t dispatch(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_RTYPE:                       nxt = S_EXEC_R;
      OP_LW, OP_SW:                   nxt = S_MEM_ADDR;
      OP_BEQ, OP_BNE:                 nxt = S_BRANCH;
      OP_J:                           nxt = S_JUMP;
      OP_JAL:                         nxt = S_JAL;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: nxt = S_EXEC_I;
      default:                        nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

  // ALU operation for the immediate-arithmetic group.
  function automatic logic [3:0] imm_alu_op(input logic [5:0] op);
    logic [3:0] code;
    case (op)
      OP_ADDIU: code = ALU_ADDU;
      OP_SLTI:  code = ALU_SLT;
      OP_SLTIU: code = ALU_SLTU;
      OP_ANDI:  code = ALU_AND;
      OP_ORI:   code = ALU_OR;
      OP_XORI:  code = ALU_XOR;
      OP_LUI:   code = ALU_LUI;
      default:  code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control-word decode for the multi-cycle control FSM.
module mc_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op_reg,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  // Map the current state (and latched opcode) to datapath controls
  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a latch.
    ctrl          = '0;
    ctrl.sign_ext = 1'b1;
    case (state)
      S_RESET: begin
        ctrl.sign_ext = 1'b0;
        ctrl.alu_op   = ALU_ADD;
      end
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
        // The IR holds the new instruction here; OpReg is only loaded at the end
        ctrl.illegal   = (dispatch(op) == S_FETCH);
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = RDST_RD;
        ctrl.mem_to_reg = M2R_ALUOUT;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_LW_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = RDST_RT;
        ctrl.mem_to_reg = M2R_MDR;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.branch_ne     = op_reg[0];
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_JAL: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = RDST_RA;
        ctrl.mem_to_reg = M2R_PC;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = imm_alu_op(op_reg);
        ctrl.sign_ext  = !(op_reg inside {OP_ANDI, OP_ORI, OP_XORI});
      end
      S_I_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = RDST_RT;
        ctrl.mem_to_reg = M2R_ALUOUT;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath, with ready/valid
// stalling on the unified instruction/data memory.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter bit          MEM_WAIT_EN = 1'b1,
  parameter int unsigned RA_REG      = 31
) (
  input  logic       CLK,
  input  logic       Reset_L,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNE,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       SignExt,
  output logic [1:0] PCSource,
  output logic [3:0] ALUop,
  output logic       Illegal
);

  // The datapath's register file only has 32 entries for the JAL link target
  if (RA_REG > 31) begin : g_ra_range
    $error("RA_REG must index one of 32 registers");
  end

  state_t     state;
  logic [5:0] op_reg;
  logic       mem_ready;
  ctrl_t      ctrl;

  assign mem_ready = MEM_WAIT_EN ? MemReady : 1'b1;

  // State register, opcode latch and next-state sequencing
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state  <= S_RESET;
      op_reg <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (state)
        S_RESET:    state <= S_FETCH;
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          op_reg <= Op;
          state  <= dispatch(Op);
        end
        S_EXEC_R:   state <= S_R_WB;
        S_MEM_ADDR: state <= (op_reg == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (mem_ready) state <= S_LW_WB;
        S_MEM_WR:   if (mem_ready) state <= S_FETCH;
        S_EXEC_I:   state <= S_I_WB;
        S_R_WB, S_LW_WB, S_BRANCH, S_JUMP, S_JAL, S_I_WB: state <= S_FETCH;
        default:    state <= S_FETCH;
      endcase
    end
  end

  mc_output_decode u_decode (
    .state    (state),
    .op_reg   (op_reg),
    .op       (Op),
    .mem_ready(mem_ready),
    .ctrl     (ctrl)
  );

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign BranchNE    = ctrl.branch_ne;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign SignExt     = ctrl.sign_ext;
  assign PCSource    = ctrl.pc_source;
  assign ALUop       = ctrl.alu_op;
  assign Illegal     = ctrl.illegal;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the datapath muxes and write enables. Issues a 4-bit ALUop to the existing ALU control decoder: direct ALU code, or 4'b1111 meaning "decode funct".
- Stalls on a ready/valid memory handshake so one unified memory of any latency serves instruction fetch and data access.

Parameters:
- MEM_WAIT_EN, 1: 1 = honour MemReady; 0 = treat MemReady as constant 1 (zero-wait memory).
- RA_REG, 31: informational; register index the datapath selects when RegDst=2'b10 (JAL).

Ports:
- CLK  in  1  system clock, rising edge.
- Reset_L  in  1  asynchronous active-low reset.
- Op  in  6  opcode field of the instruction register.
- MemReady  in  1  memory completed the current read/write this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if branch condition holds.
- BranchNE  out  1  0 = take branch on ALU Zero, 1 = take branch on !Zero.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  2  writeback source: 00 ALUOut, 01 MDR, 10 PC.
- RegDst  out  2  destination register: 00 rt, 01 rd, 10 RA_REG.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU B input: 00 rt, 01 const 4, 10 extended imm, 11 extended imm<<2.
- SignExt  out  1  immediate extension: 1 = sign-extend, 0 = zero-extend.
- PCSource  out  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target.
- ALUop  out  4  ALU control code, or 4'b1111 = use funct.
- Illegal  out  1  one-cycle pulse on an unsupported opcode.

Behaviour:
- Registered state; all outputs are a Moore decode of the state and of the opcode latched in DECODE (OpReg, 6 bits).
- Async reset: state = S_RESET, OpReg = 0. In S_RESET every output is 0 except ALUop = 4'b0010. The first clock edge after Reset_L rises enters FETCH.
- Unlisted outputs are 0. SignExt is 1 except in ANDI/ORI/XORI EXEC.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=0010, PCSource=00.
  - While MemReady=0: stay in FETCH with IRWrite=0 and PCWrite=0.
  - When MemReady=1: IRWrite=1 and PCWrite=1 that cycle; go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=0010 (branch target). Latch Op into OpReg, then dispatch:
  - R-type 000000 -> EXEC_R.
  - LW 100011 / SW 101011 -> MEM_ADDR.
  - BEQ 000100 / BNE 000101 -> BRANCH.
  - J 000010 -> JUMP.
  - JAL 000011 -> JAL.
  - ADDI 001000, ADDIU 001001, SLTI 001010, SLTIU 001011, ANDI 001100, ORI 001101, XORI 001110, LUI 001111 -> EXEC_I.
  - Any other opcode: Illegal=1 in DECODE, next state FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUop=1111 -> R_WB.
- R_WB: RegWrite=1, RegDst=01, MemtoReg=00 -> FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUop=0010 -> MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: MemRead=1, IorD=1. Hold until MemReady=1, then -> LW_WB.
- LW_WB: RegWrite=1, RegDst=00, MemtoReg=01 -> FETCH.
- MEM_WR: MemWrite=1, IorD=1. Hold until MemReady=1, then -> FETCH. MemWrite stays asserted for every wait cycle.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=0110, PCWriteCond=1, PCSource=01, BranchNE=OpReg[0] -> FETCH.
- JUMP: PCWrite=1, PCSource=10 -> FETCH.
- JAL: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10 -> FETCH. The datapath samples PC before the update.
- EXEC_I: ALUSrcA=1, ALUSrcB=10 -> I_WB. ALUop per opcode:
  - ADDI 0010, ADDIU 1000, SLTI 0111, SLTIU 1011.
  - ANDI 0000, ORI 0001, XORI 1010 (all with SignExt=0).
  - LUI 1110.
- I_WB: RegWrite=1, RegDst=00, MemtoReg=00 -> FETCH.
- Latency at zero wait:
  - R-type, I-type, SW: 4 cycles.
  - LW: 5 cycles.
  - BEQ, BNE, J, JAL: 3 cycles.
  - Each MemReady=0 cycle in FETCH, MEM_RD or MEM_WR adds one cycle.
- MemReady is ignored in every state except FETCH, MEM_RD and MEM_WR.
- Reset asserted mid-instruction (including during a memory wait): outputs drop to S_RESET values immediately, without waiting for a clock edge. No partial write completes after the reset edge.
- An unreachable state encoding goes to FETCH on the next clock with all outputs 0.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants;
  - ALU control codes (the ones the ALU control decoder uses, plus ALUOP_FUNCT = 4'b1111);
  - mux-select encodings for MemtoReg, RegDst, ALUSrcB and PCSource;
  - the state enum.
- Optional sub-module mc_output_decode: purely combinational, maps state and OpReg to the control word. The FSM register and next-state logic stay in multicycle_control.

Test Plan:
- Reset_L low in MEM_WR with MemWrite=1 -> MemWrite=0 immediately; after release, S_RESET then FETCH with MemRead=1, IorD=0.
- LW (Op=100011), MemReady always 1 -> FETCH, DECODE, MEM_ADDR, MEM_RD, LW_WB. RegWrite=1 with MemtoReg=01 only in cycle 5; back in FETCH on cycle 6.
- FETCH with MemReady=0 for 3 cycles, then 1 -> 4 cycles in FETCH; IRWrite=PCWrite=1 only on the 4th.
- BNE (000101) -> BRANCH cycle shows ALUop=0110, PCWriteCond=1, BranchNE=1, PCSource=01. BEQ gives the same but with BranchNE=0.
- ORI (001101) -> EXEC_I shows ALUop=0001, SignExt=0, ALUSrcB=10. ADDIU (001001) -> ALUop=1000, SignExt=1.
- Op=111111 -> Illegal=1 for exactly one cycle in DECODE, no RegWrite/MemWrite, next state FETCH. JAL (000011) -> one cycle with PCWrite=1, RegWrite=1, RegDst=10, MemtoReg=10.
